// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan controller.
//   state_t : scan FSM states
//   NUM_CH  : number of decoder outputs being scanned
//   CH_W    : width of a channel select
package decoder_scan_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CH_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status handshake between a scan requester and decoder_scan_ctrl.
//   start, stop        : scan request / abort levels
//   mask, dwell, cont  : scan programming, latched by the controller at start
//   busy, done         : scan in progress / one-cycle completion pulse
// Modports: master drives requests, slave (the controller) drives status.
interface decoder_scan_ctrl_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               cont;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mask, dwell, cont,
        input  busy, done
    );

    modport slave (
        input  start, stop, mask, dwell, cont,
        output busy, done
    );
endinterface

// File: rtl/decoder_scan_ctrl_next_chan_find.sv
// Combinational channel search over a channel mask.
//   mask  : set bits are channels taking part in the scan
//   cur   : channel currently selected
//   next  : lowest set bit strictly above cur (valid when found)
//   found : a set bit exists above cur
//   first : lowest set bit of mask (0 when mask is empty)
module next_chan_find
    import decoder_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   next,
    output logic              found,
    output logic [CH_W-1:0]   first
);

    // Walk from the top channel down so the last hit is the lowest index.
    always_comb begin
        next  = '0;
        found = 1'b0;
        first = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (mask[CH_W'(NUM_CH - 1 - k)]) begin
                first = CH_W'(NUM_CH - 1 - k);
                if (CH_W'(NUM_CH - 1 - k) > cur) begin
                    next  = CH_W'(NUM_CH - 1 - k);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving the select/enable inputs of a 3-to-8 decoder.
// Steps through the channels set in mask, holding e high for max(dwell,1)
// cycles per channel with a one-cycle e-low gap between channels; single
// pass or continuous, abortable with stop.
//   clk, rst_n    : clock, asynchronous active-low reset
//   ctrl (slave)  : start/stop/mask/dwell/cont in, busy/done out
//   s_0..s_2      : decoder channel select, s_0 is the LSB
//   e             : decoder enable
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_scan_ctrl_if.slave   ctrl,
    output logic                 s_0,
    output logic                 s_1,
    output logic                 s_2,
    output logic                 e
);

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_sh;
    logic [NUM_CH-1:0]  mask_sh;
    logic               cont_sh;
    logic               last;
    logic [CH_W-1:0]    sel;
    logic               e_q;
    logic               busy_q;
    logic               done_q;

    logic [NUM_CH-1:0]  find_mask;
    logic [CH_W-1:0]    nxt;
    logic               found;
    logic [CH_W-1:0]    first;

    // One search block serves both decisions: in IDLE it looks at the live
    // mask to pick the starting channel, afterwards at the latched copy.
    assign find_mask = (state == IDLE) ? ctrl.mask : mask_sh;

    next_chan_find u_find (
        .mask  (find_mask),
        .cur   (sel),
        .next  (nxt),
        .found (found),
        .first (first)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dwell_sh <= '0;
            mask_sh  <= '0;
            cont_sh  <= 1'b0;
            last     <= 1'b0;
            sel      <= '0;
            e_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl.start && !ctrl.stop) begin
                        mask_sh  <= ctrl.mask;
                        dwell_sh <= (ctrl.dwell == '0) ? DWELL_W'(1) : ctrl.dwell;
                        cont_sh  <= ctrl.cont;
                        cnt      <= '0;
                        if (ctrl.mask != '0) begin
                            sel    <= first;
                            e_q    <= 1'b1;
                            busy_q <= 1'b1;
                            state  <= ACTIVE;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                ACTIVE: begin
                    if (ctrl.stop) begin
                        e_q    <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (cnt == dwell_sh - DWELL_W'(1)) begin
                        // Select moves on the edge that drops e, so it is
                        // already stable for the whole gap cycle.
                        e_q   <= 1'b0;
                        cnt   <= '0;
                        state <= GAP;
                        if (found) begin
                            sel  <= nxt;
                            last <= 1'b0;
                        end else if (cont_sh) begin
                            sel  <= first;
                            last <= 1'b0;
                        end else begin
                            last <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end

                GAP: begin
                    if (ctrl.stop || last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        e_q   <= 1'b1;
                        state <= ACTIVE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {s_2, s_1, s_0} = sel;
    assign e               = e_q;
    assign ctrl.busy       = busy_q;
    assign ctrl.done       = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: per-cycle traces of e/busy/done/select
// compared against hand-built expected timelines.
module tb_decoder_scan_ctrl;

    localparam int MAXS = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic s_0, s_1, s_2, e;

    decoder_scan_ctrl_if #(.DWELL_W(8)) ctrl_bus ();

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ctrl_bus),
        .s_0   (s_0),
        .s_1   (s_1),
        .s_2   (s_2),
        .e     (e)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic       tr_e    [MAXS];
    logic       tr_busy [MAXS];
    logic       tr_done [MAXS];
    logic [2:0] tr_sel  [MAXS];
    logic       ex_e    [MAXS];
    logic       ex_busy [MAXS];
    logic       ex_done [MAXS];
    logic [2:0] ex_sel  [MAXS];
    int         ex_len;

    // Record n consecutive negedge samples, starting at the current negedge.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr_e[i]    = e;
            tr_busy[i] = ctrl_bus.busy;
            tr_done[i] = ctrl_bus.done;
            tr_sel[i]  = {s_2, s_1, s_0};
            @(negedge clk);
        end
    endtask

    // Expected timeline: per listed channel, d cycles enabled then one gap,
    // then the done cycle and one idle cycle.
    task automatic build_expect(input int chs[8], input int nch, input int d);
        int idx;
        idx = 0;
        for (int c = 0; c < nch; c++) begin
            for (int k = 0; k < d; k++) begin
                ex_e[idx] = 1'b1; ex_busy[idx] = 1'b1; ex_done[idx] = 1'b0;
                ex_sel[idx] = 3'(chs[c]);
                idx++;
            end
            ex_e[idx] = 1'b0; ex_busy[idx] = 1'b1; ex_done[idx] = 1'b0; ex_sel[idx] = '0;
            idx++;
        end
        ex_e[idx] = 1'b0; ex_busy[idx] = 1'b0; ex_done[idx] = 1'b1; ex_sel[idx] = '0;
        idx++;
        ex_e[idx] = 1'b0; ex_busy[idx] = 1'b0; ex_done[idx] = 1'b0; ex_sel[idx] = '0;
        idx++;
        ex_len = idx;
    endtask

    // Called at a negedge; returns at the negedge just after the sampling edge.
    task automatic do_start(input logic [7:0] m, input logic [7:0] d, input logic c);
        ctrl_bus.mask  = m;
        ctrl_bus.dwell = d;
        ctrl_bus.cont  = c;
        ctrl_bus.start = 1'b1;
        @(negedge clk);
        ctrl_bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({s_2, s_1, s_0, e, ctrl_bus.busy, ctrl_bus.done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_async: got sel/e/busy/done=%b, expected 000000",
                     {s_2, s_1, s_0, e, ctrl_bus.busy, ctrl_bus.done});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({s_2, s_1, s_0, e, ctrl_bus.busy, ctrl_bus.done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_release: got sel/e/busy/done=%b, expected 000000",
                     {s_2, s_1, s_0, e, ctrl_bus.busy, ctrl_bus.done});
        end
    endtask

    task automatic test_single_pass();
        int nb, nd;
        do_start(8'b1000_0101, 8'd3, 1'b0);
        build_expect('{0, 2, 7, 0, 0, 0, 0, 0}, 3, 3);
        capture(ex_len);
        nb = 0; nd = 0;
        for (int i = 0; i < ex_len; i++) begin
            nb += int'(tr_busy[i]);
            nd += int'(tr_done[i]);
            vectors++;
            if (tr_e[i] !== ex_e[i] || tr_busy[i] !== ex_busy[i] || tr_done[i] !== ex_done[i] ||
                (ex_e[i] && tr_sel[i] !== ex_sel[i])) begin
                miscompares++;
                $display("FAIL single_pass[%0d]: got e=%b busy=%b done=%b sel=%0d, expected e=%b busy=%b done=%b sel=%0d",
                         i, tr_e[i], tr_busy[i], tr_done[i], tr_sel[i], ex_e[i], ex_busy[i], ex_done[i], ex_sel[i]);
            end
        end
        vectors++;
        if (nb !== 12) begin
            miscompares++;
            $display("FAIL single_pass_busy_cycles: got %0d, expected 12", nb);
        end
        vectors++;
        if (nd !== 1) begin
            miscompares++;
            $display("FAIL single_pass_done_count: got %0d, expected 1", nd);
        end
    endtask

    task automatic test_zero_mask();
        do_start(8'h00, 8'd3, 1'b0);
        capture(4);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tr_e[i] !== 1'b0 || tr_busy[i] !== 1'b0 || tr_done[i] !== (i == 0)) begin
                miscompares++;
                $display("FAIL zero_mask[%0d]: got e=%b busy=%b done=%b, expected e=0 busy=0 done=%b",
                         i, tr_e[i], tr_busy[i], tr_done[i], (i == 0));
            end
        end
    endtask

    task automatic test_dwell_zero();
        int nb;
        do_start(8'hFF, 8'd0, 1'b0);
        build_expect('{0, 1, 2, 3, 4, 5, 6, 7}, 8, 1);
        capture(ex_len);
        nb = 0;
        for (int i = 0; i < ex_len; i++) begin
            nb += int'(tr_busy[i]);
            vectors++;
            if (tr_e[i] !== ex_e[i] || tr_busy[i] !== ex_busy[i] || tr_done[i] !== ex_done[i] ||
                (ex_e[i] && tr_sel[i] !== ex_sel[i])) begin
                miscompares++;
                $display("FAIL dwell_zero[%0d]: got e=%b busy=%b done=%b sel=%0d, expected e=%b busy=%b done=%b sel=%0d",
                         i, tr_e[i], tr_busy[i], tr_done[i], tr_sel[i], ex_e[i], ex_busy[i], ex_done[i], ex_sel[i]);
            end
        end
        vectors++;
        if (nb !== 16) begin
            miscompares++;
            $display("FAIL dwell_zero_busy_cycles: got %0d, expected 16", nb);
        end
    endtask

    task automatic test_cont_stop();
        do_start(8'b0100_0010, 8'd3, 1'b1);
        build_expect('{1, 6, 1, 6, 0, 0, 0, 0}, 4, 3);
        capture(13);
        for (int i = 0; i < 13; i++) begin
            vectors++;
            if (tr_e[i] !== ex_e[i] || tr_busy[i] !== ex_busy[i] || tr_done[i] !== ex_done[i] ||
                (ex_e[i] && tr_sel[i] !== ex_sel[i])) begin
                miscompares++;
                $display("FAIL cont_wrap[%0d]: got e=%b busy=%b done=%b sel=%0d, expected e=%b busy=%b done=%b sel=%0d",
                         i, tr_e[i], tr_busy[i], tr_done[i], tr_sel[i], ex_e[i], ex_busy[i], ex_done[i], ex_sel[i]);
            end
        end
        // Second cycle of the second visit to channel 6: abort here.
        vectors++;
        if (e !== 1'b1 || {s_2, s_1, s_0} !== 3'd6) begin
            miscompares++;
            $display("FAIL cont_pre_stop: got e=%b sel=%0d, expected e=1 sel=6", e, {s_2, s_1, s_0});
        end
        ctrl_bus.stop = 1'b1;
        @(negedge clk);
        ctrl_bus.stop = 1'b0;
        vectors++;
        if ({e, ctrl_bus.busy, ctrl_bus.done} !== 3'b001) begin
            miscompares++;
            $display("FAIL stop_response: got e/busy/done=%b, expected 001", {e, ctrl_bus.busy, ctrl_bus.done});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({e, ctrl_bus.busy, ctrl_bus.done} !== 3'b000) begin
                miscompares++;
                $display("FAIL stop_idle[%0d]: got e/busy/done=%b, expected 000", i, {e, ctrl_bus.busy, ctrl_bus.done});
            end
        end
    endtask

    task automatic test_busy_ignore();
        do_start(8'b1000_0101, 8'd3, 1'b0);
        build_expect('{0, 2, 7, 0, 0, 0, 0, 0}, 3, 3);
        for (int i = 0; i < ex_len; i++) begin
            tr_e[i]    = e;
            tr_busy[i] = ctrl_bus.busy;
            tr_done[i] = ctrl_bus.done;
            tr_sel[i]  = {s_2, s_1, s_0};
            if (i == 1) begin
                ctrl_bus.mask  = 8'hFF;
                ctrl_bus.dwell = 8'd1;
                ctrl_bus.cont  = 1'b1;
                ctrl_bus.start = 1'b1;
            end
            if (i == 2) ctrl_bus.start = 1'b0;
            if (i == 6) ctrl_bus.start = 1'b1;
            if (i == 7) ctrl_bus.start = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < ex_len; i++) begin
            vectors++;
            if (tr_e[i] !== ex_e[i] || tr_busy[i] !== ex_busy[i] || tr_done[i] !== ex_done[i] ||
                (ex_e[i] && tr_sel[i] !== ex_sel[i])) begin
                miscompares++;
                $display("FAIL busy_ignore[%0d]: got e=%b busy=%b done=%b sel=%0d, expected e=%b busy=%b done=%b sel=%0d",
                         i, tr_e[i], tr_busy[i], tr_done[i], tr_sel[i], ex_e[i], ex_busy[i], ex_done[i], ex_sel[i]);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        ctrl_bus.mask  = 8'h0F;
        ctrl_bus.dwell = 8'd2;
        ctrl_bus.cont  = 1'b0;
        ctrl_bus.start = 1'b1;
        ctrl_bus.stop  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) begin
                ctrl_bus.start = 1'b0;
                ctrl_bus.stop  = 1'b0;
            end
            vectors++;
            if ({e, ctrl_bus.busy, ctrl_bus.done} !== 3'b000) begin
                miscompares++;
                $display("FAIL start_stop_idle[%0d]: got e/busy/done=%b, expected 000", i, {e, ctrl_bus.busy, ctrl_bus.done});
            end
        end
    endtask

    task automatic test_async_reset();
        do_start(8'b0100_0010, 8'd3, 1'b1);
        capture(3);
        vectors++;
        if ({e, ctrl_bus.busy, s_2, s_1, s_0} !== 5'b01_110) begin
            miscompares++;
            $display("FAIL gap_before_reset: got e/busy/sel=%b, expected 01110", {e, ctrl_bus.busy, s_2, s_1, s_0});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({s_2, s_1, s_0, e, ctrl_bus.busy, ctrl_bus.done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_mid_gap: got sel/e/busy/done=%b, expected 000000",
                     {s_2, s_1, s_0, e, ctrl_bus.busy, ctrl_bus.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({s_2, s_1, s_0, e, ctrl_bus.busy, ctrl_bus.done} !== 6'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle[%0d]: got sel/e/busy/done=%b, expected 000000",
                         i, {s_2, s_1, s_0, e, ctrl_bus.busy, ctrl_bus.done});
            end
        end
        do_start(8'h10, 8'd1, 1'b0);
        build_expect('{4, 0, 0, 0, 0, 0, 0, 0}, 1, 1);
        capture(ex_len);
        for (int i = 0; i < ex_len; i++) begin
            vectors++;
            if (tr_e[i] !== ex_e[i] || tr_busy[i] !== ex_busy[i] || tr_done[i] !== ex_done[i] ||
                (ex_e[i] && tr_sel[i] !== ex_sel[i])) begin
                miscompares++;
                $display("FAIL one_channel[%0d]: got e=%b busy=%b done=%b sel=%0d, expected e=%b busy=%b done=%b sel=%0d",
                         i, tr_e[i], tr_busy[i], tr_done[i], tr_sel[i], ex_e[i], ex_busy[i], ex_done[i], ex_sel[i]);
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctrl_bus.start = 1'b0;
        ctrl_bus.stop  = 1'b0;
        ctrl_bus.mask  = 8'h00;
        ctrl_bus.dwell = 8'd0;
        ctrl_bus.cont  = 1'b0;
        test_reset();
        test_single_pass();
        test_zero_mask();
        test_dwell_zero();
        test_cont_stop();
        test_busy_ignore();
        test_start_stop_idle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
